// File: rtl/mem_bus_arbiter.sv
// Arbitrates IF and pre-MEM requesters onto one sram-like port.
// In-order owner FIFO routes each response back to its requester.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_iscache,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic        data_iscache,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic        m_iscache,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic        protocol_err
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT = MAX_OUTSTANDING[CW-1:0];
  localparam logic [SW-1:0] LIMIT = STARVE_LIMIT[SW-1:0];

  logic [MAX_OUTSTANDING-1:0] own_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic          lock;
  logic          lock_own;
  logic          err;

  logic sel_valid;
  logic sel_data;
  logic own_req;
  logic full;
  logic accept;
  logic resp;
  logic head;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    if (lock) begin
      sel_valid = 1'b1;
      sel_data  = lock_own;
    end else if (data_req && !(inst_req && starve >= LIMIT)) begin
      sel_valid = 1'b1;
      sel_data  = 1'b1;
    end else if (inst_req) begin
      sel_valid = 1'b1;
    end
  end

  assign own_req = sel_valid && (sel_data ? data_req : inst_req);
  assign full    = (cnt == MAX_CNT);
  assign m_req   = resetn && own_req && !full;
  assign accept  = m_req && m_addr_ok;

  assign m_wr      = sel_data && data_wr;
  assign m_size    = sel_data ? data_size : 3'd2;
  assign m_wstrb   = sel_data ? data_wstrb : 4'd0;
  assign m_addr    = sel_data ? data_addr : inst_addr;
  assign m_iscache = sel_data ? data_iscache : inst_iscache;
  assign m_wdata   = sel_data ? data_wdata : 32'd0;

  assign inst_addr_ok = accept && !sel_data;
  assign data_addr_ok = accept && sel_data;

  assign head = own_q[rd_ptr];
  assign resp = resetn && m_data_ok && (cnt != '0);

  assign inst_data_ok = resp && !head;
  assign data_data_ok = resp && head;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign outstanding  = cnt;
  assign protocol_err = err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      own_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      starve   <= '0;
      lock     <= 1'b0;
      lock_own <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        own_q[wr_ptr] <= sel_data;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (resp)
        rd_ptr <= rd_ptr + AW'(1);
      if (accept && !resp)
        cnt <= cnt + CW'(1);
      else if (!accept && resp)
        cnt <= cnt - CW'(1);
      // hold the grant until the address phase completes
      if (accept) begin
        lock <= 1'b0;
      end else if (m_req) begin
        lock     <= 1'b1;
        lock_own <= sel_data;
      end
      if (!inst_req || (accept && !sel_data))
        starve <= '0;
      else if (accept && starve != LIMIT)
        starve <= starve + SW'(1);
      if (m_data_ok && cnt == '0)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter with an owner scoreboard.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_iscache;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic        data_iscache;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req;
  logic        m_wr;
  logic [2:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr;
  logic        m_iscache;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int checks = 0;
  int fails  = 0;
  bit sb[$];

  mem_bus_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_iscache(inst_iscache), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_iscache(data_iscache),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_iscache(m_iscache),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0; inst_iscache = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
    data_addr = 0; data_iscache = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    @(negedge clk);
    checks++;
    if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      fails++;
      $display("FAIL rst_forced: got %b exp 00000",
        {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    tick();
    idle_inputs();
    resetn = 1;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_state: got out=%0d err=%b exp 0 0", outstanding, protocol_err);
    end
    checks++;
    if ({m_req, m_wr, m_wstrb, m_addr, m_wdata, inst_data_ok, data_data_ok} !== '0) begin
      fails++;
      $display("FAIL idle_outs: got req=%b addr=%h exp all 0", m_req, m_addr);
    end
    tick();
  endtask

  task automatic test_starvation();
    bit o;
    bit exp_d;
    logic [31:0] r;
    for (int i = 0; i < 5; i++) begin
      inst_req = 1; data_req = 1; data_wr = 0;
      inst_addr = 32'h1000; data_addr = 32'h2000;
      m_addr_ok = 1; m_data_ok = (i > 0);
      r = 32'hA0 + i; m_rdata = r;
      exp_d = (i < 4);
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || m_addr !== (exp_d ? 32'h2000 : 32'h1000)
          || data_addr_ok !== exp_d || inst_addr_ok !== !exp_d) begin
        fails++;
        $display("FAIL starve_grant%0d: got req=%b addr=%h dok=%b iok=%b exp data=%b",
          i, m_req, m_addr, data_addr_ok, inst_addr_ok, exp_d);
      end
      if (i > 0) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL starve_sb: got empty scoreboard exp entry");
        end else begin
          o = sb.pop_front();
          if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
            fails++;
            $display("FAIL starve_resp%0d: got d=%b i=%b exp owner_data=%b rdata=%h",
              i, data_data_ok, inst_data_ok, o, r);
          end
        end
      end
      sb.push_back(exp_d);
      tick();
    end
    inst_req = 0; data_req = 0; m_addr_ok = 0;
    m_data_ok = 1; r = 32'hA5; m_rdata = r;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL starve_drain_sb: got empty scoreboard exp entry");
    end else begin
      o = sb.pop_front();
      if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
        fails++;
        $display("FAIL starve_drain: got d=%b i=%b exp owner_data=%b", data_data_ok, inst_data_ok, o);
      end
    end
    tick();
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL starve_out: got %0d exp 0", outstanding);
    end
    tick();
  endtask

  task automatic test_lock();
    bit o;
    logic [31:0] r;
    for (int c = 0; c < 4; c++) begin
      inst_req = 1; inst_addr = 32'h3000;
      data_req = (c >= 1); data_addr = 32'h4000; data_wr = 1;
      data_wdata = 32'hCAFE; data_wstrb = 4'h3; data_size = 3'd1;
      m_addr_ok = (c == 3);
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || m_addr !== 32'h3000 || m_wr !== 1'b0 || m_size !== 3'd2
          || m_wstrb !== 4'h0 || inst_addr_ok !== (c == 3) || data_addr_ok !== 1'b0) begin
        fails++;
        $display("FAIL lock_hold%0d: got req=%b addr=%h wr=%b size=%0d iok=%b dok=%b exp inst grant",
          c, m_req, m_addr, m_wr, m_size, inst_addr_ok, data_addr_ok);
      end
      if (c == 3) sb.push_back(1'b0);
      tick();
    end
    inst_req = 0; data_req = 1; m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (m_addr !== 32'h4000 || m_wr !== 1'b1 || m_wdata !== 32'hCAFE || m_wstrb !== 4'h3
        || m_size !== 3'd1 || data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL lock_next_data: got addr=%h wr=%b wdata=%h dok=%b exp 4000 1 cafe 1",
        m_addr, m_wr, m_wdata, data_addr_ok);
    end
    sb.push_back(1'b1);
    tick();
    data_req = 0; data_wr = 0; m_addr_ok = 0;
    for (int k = 0; k < 2; k++) begin
      m_data_ok = 1; r = 32'hB0 + k; m_rdata = r;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL lock_sb: got empty scoreboard exp entry");
      end else begin
        o = sb.pop_front();
        if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
          fails++;
          $display("FAIL lock_resp%0d: got d=%b i=%b exp owner_data=%b", k, data_data_ok, inst_data_ok, o);
        end
      end
      tick();
    end
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL lock_out: got %0d exp 0", outstanding);
    end
    tick();
  endtask

  task automatic test_full();
    bit o;
    bit d;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      d = (k % 2 == 0);
      data_req = d; inst_req = !d; data_wr = 1;
      data_addr = 32'h5000 + k; inst_addr = 32'h6000 + k;
      m_addr_ok = 1;
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || data_addr_ok !== d || inst_addr_ok !== !d) begin
        fails++;
        $display("FAIL full_fill%0d: got req=%b dok=%b iok=%b exp data=%b",
          k, m_req, data_addr_ok, inst_addr_ok, d);
      end
      sb.push_back(d);
      tick();
    end
    inst_req = 0; data_req = 1;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || data_addr_ok !== 1'b0 || outstanding !== 3'd4) begin
      fails++;
      $display("FAIL full_block: got req=%b dok=%b out=%0d exp 0 0 4", m_req, data_addr_ok, outstanding);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      data_req = (k == 0);
      m_data_ok = 1; r = 32'h11 * (k + 1); m_rdata = r;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (m_req !== 1'b0) begin
          fails++;
          $display("FAIL full_pop_noreleif: got req=%b exp 0", m_req);
        end
      end
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL full_sb: got empty scoreboard exp entry");
      end else begin
        o = sb.pop_front();
        if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
          fails++;
          $display("FAIL full_resp%0d: got d=%b i=%b exp owner_data=%b rdata=%h",
            k, data_data_ok, inst_data_ok, o, r);
        end
      end
      tick();
    end
    data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL full_out: got %0d exp 0", outstanding);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit o;
    logic [31:0] r;
    for (int k = 0; k < 2; k++) begin
      data_req = (k == 0); inst_req = (k == 1);
      data_addr = 32'h7000; inst_addr = 32'h8000; m_addr_ok = 1;
      @(negedge clk);
      sb.push_back(k == 0);
      tick();
    end
    inst_req = 0; data_req = 1; m_addr_ok = 1;
    m_data_ok = 1; r = 32'h55; m_rdata = r;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd2 || data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_pre: got out=%0d dok=%b exp 2 1", outstanding, data_addr_ok);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL b2b_sb: got empty scoreboard exp entry");
    end else begin
      o = sb.pop_front();
      if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
        fails++;
        $display("FAIL b2b_head: got d=%b i=%b exp owner_data=%b", data_data_ok, inst_data_ok, o);
      end
    end
    sb.push_back(1'b1);
    tick();
    data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd2) begin
      fails++;
      $display("FAIL b2b_count: got %0d exp 2", outstanding);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      m_data_ok = 1; r = 32'hC0 + k; m_rdata = r;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL b2b_drain_sb: got empty scoreboard exp entry");
      end else begin
        o = sb.pop_front();
        if ({data_data_ok, inst_data_ok} !== {o, !o} || (o ? data_rdata : inst_rdata) !== r) begin
          fails++;
          $display("FAIL b2b_drain%0d: got d=%b i=%b exp owner_data=%b", k, data_data_ok, inst_data_ok, o);
        end
      end
      tick();
    end
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin
      fails++;
      $display("FAIL b2b_out: got %0d exp 0", outstanding);
    end
    tick();
  endtask

  task automatic test_protocol_err();
    idle_inputs();
    m_data_ok = 1; m_rdata = 32'h77;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      fails++;
      $display("FAIL perr_no_ok: got i=%b d=%b exp 0 0", inst_data_ok, data_data_ok);
    end
    tick();
    m_data_ok = 0;
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b1) begin
      fails++;
      $display("FAIL perr_set: got %b exp 1", protocol_err);
    end
    tick();
    inst_req = 1; inst_addr = 32'h9000; m_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b1 || inst_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL perr_sticky: got err=%b iok=%b exp 1 1", protocol_err, inst_addr_ok);
    end
    tick();
    inst_req = 0; m_addr_ok = 0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd1) begin
      fails++;
      $display("FAIL perr_inflight: got %0d exp 1", outstanding);
    end
    tick();
    resetn = 0;
    tick();
    resetn = 1;
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b0 || outstanding !== 3'd0) begin
      fails++;
      $display("FAIL perr_clear: got err=%b out=%0d exp 0 0", protocol_err, outstanding);
    end
    tick();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    test_reset();
    test_starvation();
    test_lock();
    test_full();
    test_back_to_back();
    test_protocol_err();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d entries exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester and the pre-MEM data requester.
- Upstream sits between the IF/pre-MEM stages; downstream sits in front of the cache/AXI bridge.
- Grants data over inst by priority, with a starvation limit so inst still gets a grant.
- Locks a grant until the address handshake completes, and tracks outstanding transactions in order so each data_ok/rdata returns to its owner.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of 2, at least 2
STARVE_LIMIT, 4, consecutive data grants while inst is waiting before inst is forced; at least 1

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_req  in  1  inst request; held until inst_addr_ok
inst_addr  in  32  inst physical address
inst_iscache  in  1  inst cached attribute
inst_addr_ok  out  1  inst address accepted
inst_data_ok  out  1  inst read data valid
inst_rdata  out  32  inst read data
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  3  access size
data_wstrb  in  4  byte strobes
data_addr  in  32  data physical address
data_iscache  in  1  data cached attribute
data_wdata  in  32  store data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data response (load data or store ack)
data_rdata  out  32  load data
m_req  out  1  downstream request
m_wr  out  1  downstream write
m_size  out  3  downstream size
m_wstrb  out  4  downstream strobes
m_addr  out  32  downstream address
m_iscache  out  1  downstream cached attribute
m_wdata  out  32  downstream write data
m_addr_ok  in  1  downstream address accepted
m_data_ok  in  1  downstream response; responses arrive in order
m_rdata  in  32  downstream read data
outstanding  out  log2(MAX_OUTSTANDING)+1  count of pending responses
protocol_err  out  1  sticky: m_data_ok seen with no transaction outstanding

Behaviour:
- Reset (resetn=0 at a clk edge) clears:
  - owner FIFO, outstanding=0, lock, starvation counter, protocol_err=0.
  - Transactions still in flight at reset are dropped.
- While resetn=0, m_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced 0.
- Owner selection, evaluated combinationally each cycle:
  - If lock is set, owner = locked owner.
  - Otherwise, if data_req=1 and not (inst_req=1 and starve_cnt>=STARVE_LIMIT), owner = data.
  - Otherwise, if inst_req=1, owner = inst.
  - Otherwise no owner.
- full = (outstanding == MAX_OUTSTANDING). A pop in the same cycle does not relieve full.
- Request path:
  - m_req = owner's req & !full.
  - m_* fields are muxed from the owner. For inst: m_wr=0, m_size=3'd2, m_wstrb=0, m_wdata=0.
  - Address handshake: the owner's addr_ok = m_addr_ok & m_req. The non-owner's addr_ok = 0.
- Lock:
  - Set when m_req=1 and m_addr_ok=0; it records the current owner.
  - Cleared on the cycle that m_req & m_addr_ok.
  - While locked, the grant cannot switch even if the other requester has higher priority.
- Accept (m_req & m_addr_ok): push the owner bit (1 = data) into the owner FIFO.
- Response (m_data_ok=1):
  - With outstanding>0: pop the head and drive {owner}_data_ok=1 and {owner}_rdata=m_rdata in the same cycle (combinational).
  - With outstanding=0: no pop, no data_ok, protocol_err <= 1.
- Push and pop in the same cycle: outstanding is unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Starvation counter:
  - +1 (saturating at STARVE_LIMIT) on each data accept while inst_req=1.
  - Reset to 0 on an inst accept, or on any cycle inst_req=0.
- Latency: no added cycles. Both the request and response paths are combinational; only the FIFO, counters and lock are registered.
- Non-owner rdata outputs hold m_rdata (don't-care); checkers use data_ok only.

Test Plan:
- Reset, then idle: all outputs 0, outstanding=0, protocol_err=0.
- inst_req and data_req both set, m_addr_ok=1 constant → data granted first. After 4 data accepts with inst waiting, the 5th grant goes to inst (STARVE_LIMIT=4).
- inst_req alone, m_addr_ok=0 for 3 cycles, data_req rises in cycle 2 → m_addr stays at inst_addr until m_addr_ok. Inst is accepted, then data is granted next cycle.
- Issue 4 accepts (order D,I,D,I), no m_data_ok → 5th request sees m_req=0 with outstanding=4. Four m_data_ok with rdata 0x11,0x22,0x33,0x44 → data_data_ok for 0x11, inst_data_ok for 0x22, data for 0x33, inst for 0x44; outstanding returns to 0.
- With outstanding=2, accept and m_data_ok in the same cycle → outstanding stays 2, and the head owner receives its data_ok.
- m_data_ok pulse with outstanding=0 → no data_ok pulse, protocol_err=1 and held. A resetn pulse clears it, and after reset outstanding=0.
